// File: rtl/gray_rx_checker_pkg.sv
// Shared types and defaults for the Gray-code receive checker.
// Optional feature macro: GRAY_ERRCNT_EN (saturating illegal-step counter).
package gray_rx_checker_pkg;

  localparam int unsigned GRAY_WIDTH = 4;
  localparam int unsigned GRAY_CNT_W = 8;

  // Tracking state: no reference yet / following the stream / recovering from a bad step
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Classification of one step between successive decoded samples
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

endpackage

// File: rtl/gray_rx_checker_if.sv
// Bus between a Gray-stream source / status consumer (master) and the checker (slave).
//   master drives : clr, sample_en, gray_in
//   slave drives  : bin_out, bin_valid, step_up, step_down, step_err, locked
//                   err_cnt (only when GRAY_ERRCNT_EN is defined)
interface gray_rx_checker_if
  import gray_rx_checker_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH
`ifdef GRAY_ERRCNT_EN
  , parameter int unsigned CNT_W = GRAY_CNT_W
`endif
) ();

  logic             clr;
  logic             sample_en;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_up;
  logic             step_down;
  logic             step_err;
  logic             locked;
`ifdef GRAY_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output clr, sample_en, gray_in,
    input  bin_out, bin_valid, step_up, step_down, step_err, locked, err_cnt
  );

  modport slave (
    input  clr, sample_en, gray_in,
    output bin_out, bin_valid, step_up, step_down, step_err, locked, err_cnt
  );
`else
  modport master (
    output clr, sample_en, gray_in,
    input  bin_out, bin_valid, step_up, step_down, step_err, locked
  );

  modport slave (
    input  clr, sample_en, gray_in,
    output bin_out, bin_valid, step_up, step_down, step_err, locked
  );
`endif

endinterface

// File: rtl/gray_rx_checker_gray_to_bin.sv
// Combinational Gray-to-binary decoder.
//   gray_i : Gray-coded word
//   bin_o  : binary value (bit i is the XOR of Gray bits i..WIDTH-1)
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Prefix-XOR from the MSB down, written per bit to avoid a self-referencing chain
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    assign bin_o[g] = ^(gray_i >> g);
  end

endmodule

// File: rtl/gray_rx_checker.sv
// Gray-stream receive checker: samples a Gray word on each strobe, decodes it and
// classifies the step from the previous sample as up / down / hold / illegal.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : gray_rx_checker_if.slave (clr, sample_en, gray_in in; decoded value,
//         step flags, locked and optional err_cnt out)
// Optional feature macro: GRAY_ERRCNT_EN adds a saturating illegal-step counter.
// Timing: a strobe captured at edge N produces bin_out/bin_valid/flags at edge N+1.
module gray_rx_checker
  import gray_rx_checker_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH
`ifdef GRAY_ERRCNT_EN
  , parameter int unsigned CNT_W = GRAY_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  gray_rx_checker_if.slave bus
);

  logic             smp_vld_q;
  logic [WIDTH-1:0] smp_gray_q;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] delta;
  step_e            step_c;
  state_e           state_q;
  logic [WIDTH-1:0] bin_out_q;
  logic             bin_valid_q;
  logic             step_up_q;
  logic             step_down_q;
  logic             step_err_q;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray_i (smp_gray_q),
    .bin_o  (bin_new)
  );

  // Wrap-around difference from the previous reference
  assign delta = bin_new - prev_q;

  // Step classifier
  always_comb begin
    step_c = STEP_ERR;
    if (delta == '0) begin
      step_c = STEP_HOLD;
    end else if (delta == WIDTH'(1)) begin
      step_c = STEP_UP;
    end else if (delta == '1) begin
      step_c = STEP_DOWN;
    end
  end

  // Sample stage, reference register, FSM and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_vld_q   <= 1'b0;
      smp_gray_q  <= '0;
      prev_q      <= '0;
      state_q     <= ST_EMPTY;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      // clr discards a strobe in the same cycle
      smp_vld_q <= bus.sample_en & ~bus.clr;
      if (bus.sample_en) begin
        smp_gray_q <= bus.gray_in;
      end
      bin_valid_q <= 1'b0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      step_err_q  <= 1'b0;
      if (bus.clr) begin
        // Also drops a sample already in the capture stage; bin_out is kept
        state_q <= ST_EMPTY;
      end else if (smp_vld_q) begin
        bin_out_q   <= bin_new;
        prev_q      <= bin_new;
        bin_valid_q <= 1'b1;
        case (state_q)
          ST_TRACK: begin
            step_up_q   <= (step_c == STEP_UP);
            step_down_q <= (step_c == STEP_DOWN);
            step_err_q  <= (step_c == STEP_ERR);
            if (step_c == STEP_ERR) begin
              state_q <= ST_FAULT;
            end
          end
          // Reference-only sample: no classification
          ST_EMPTY, ST_FAULT: state_q <= ST_TRACK;
          default:            state_q <= ST_EMPTY;
        endcase
      end
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.step_up   = step_up_q;
  assign bus.step_down = step_down_q;
  assign bus.step_err  = step_err_q;
  assign bus.locked    = (state_q == ST_TRACK);

`ifdef GRAY_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Saturating count of illegal steps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (bus.clr) begin
      err_cnt_q <= '0;
    end else if (smp_vld_q && (state_q == ST_TRACK) && (step_c == STEP_ERR)
                 && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
